// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types and constants for the datapath controller
// Contents: opcode_e, state_e with its ST_* constants, ALU codes, and the uop_t micro-op bundle.
package datapath_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_CLR  = 3'b001,
      OP_MOVM = 3'b010,
      OP_MOV  = 3'b011,
      OP_ADC  = 3'b100,
      OP_SBC  = 3'b101,
      OP_IL6  = 3'b110,
      OP_IL7  = 3'b111
   } opcode_e;

   typedef logic [1:0] state_e;
   localparam state_e ST_INIT = 2'd0;
   localparam state_e ST_RUN  = 2'd1;
   localparam state_e ST_MOV2 = 2'd2;

   localparam logic [2:0] ALU_ADC   = 3'b000;
   localparam logic [2:0] ALU_SBC   = 3'b001;
   localparam logic [2:0] ALU_PASSB = 3'b010;

   // Operand index 3 names the accumulator A.
   localparam logic [1:0] REG_A = 2'd3;

   typedef struct packed {
      logic       clr;
      logic [3:0] ce;
      logic [2:0] w;
      logic [1:0] sel;
      logic [2:0] s;
   } uop_t;

endpackage

// File: rtl/datapath_ctrl_instr_decode.sv
// rtl/datapath_ctrl_instr_decode.sv - combinational decode of one instruction into micro-ops
// Ports: instr (in, 8) {op, dst, kind, idx}; uop1/uop2 (out) first and second micro-op;
//        is_macro (out) two micro-ops needed; illegal (out) instruction must be discarded.
module instr_decode
   import datapath_pkg::*;
(
   input  logic [7:0] instr,
   output uop_t       uop1,
   output uop_t       uop2,
   output logic       is_macro,
   output logic       illegal
);

   opcode_e    op;
   logic [1:0] dst;
   logic       kind;
   logic [1:0] idx;

   assign op   = opcode_e'(instr[7:5]);
   assign dst  = instr[4:3];
   assign kind = instr[2];
   assign idx  = instr[1:0];

   always_comb begin
      uop1     = '0;
      uop2     = '0;
      is_macro = 1'b0;
      illegal  = 1'b0;
      case (op)
         OP_NOP: ;
         OP_CLR:  uop1.clr = 1'b1;
         OP_MOVM: uop1.ce  = 4'b0111;
         OP_MOV: begin
            if (kind) begin
               // Only R[k] <- M[k] is wired; dst==idx with dst!=A also rules out M[3].
               if (dst == REG_A || idx != dst) begin
                  illegal = 1'b1;
               end else begin
                  uop1.ce = 4'b0001 << dst;
               end
            end else if (dst != idx) begin
               if (dst == REG_A) begin
                  uop1.ce  = 4'b1000;
                  uop1.sel = idx;
                  uop1.s   = ALU_PASSB;
               end else if (idx == REG_A) begin
                  uop1.ce = 4'b0001 << dst;
                  uop1.w  = 3'b001 << dst;
               end else begin
                  // Register-to-register goes through A; A ends up holding the source.
                  uop1.ce  = 4'b1000;
                  uop1.sel = idx;
                  uop1.s   = ALU_PASSB;
                  uop2.ce  = 4'b0001 << dst;
                  uop2.w   = 3'b001 << dst;
                  is_macro = 1'b1;
               end
            end
         end
         OP_ADC, OP_SBC: begin
            if (kind || idx == REG_A) begin
               illegal = 1'b1;
            end else begin
               uop1.ce  = 4'b1000;
               uop1.sel = idx;
               uop1.s   = (op == OP_ADC) ? ALU_ADC : ALU_SBC;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - control unit issuing registered micro-ops to the 4-bit datapath
// Ports: clk, clr_i (sync active-high reset); instr_i/instr_valid_i/instr_ready_o instruction handshake;
//        dp_clr_o, dp_ce_o, dp_w_o, dp_sel_o, dp_s_o datapath controls; busy_o not in RUN; err_o illegal pulse.
module datapath_ctrl
   import datapath_pkg::*;
#(
   parameter int INIT_CLR_CYCLES = 1,
   parameter int IW              = 8
) (
   input  logic          clk,
   input  logic          clr_i,
   input  logic [IW-1:0] instr_i,
   input  logic          instr_valid_i,
   output logic          instr_ready_o,
   output logic          dp_clr_o,
   output logic [3:0]    dp_ce_o,
   output logic [2:0]    dp_w_o,
   output logic [1:0]    dp_sel_o,
   output logic [2:0]    dp_s_o,
   output logic          busy_o,
   output logic          err_o
);

   localparam int CW = (INIT_CLR_CYCLES > 1) ? $clog2(INIT_CLR_CYCLES) : 1;

   state_e        state;
   logic [CW-1:0] clr_cnt;
   uop_t          uop2_hold;
   uop_t          out_q;

   uop_t dec_uop1;
   uop_t dec_uop2;
   logic dec_macro;
   logic dec_illegal;
   logic accept;

   instr_decode u_decode (
      .instr    (instr_i),
      .uop1     (dec_uop1),
      .uop2     (dec_uop2),
      .is_macro (dec_macro),
      .illegal  (dec_illegal)
   );

   assign instr_ready_o = (state == ST_RUN);
   assign busy_o        = (state != ST_RUN);
   assign accept        = instr_valid_i && instr_ready_o;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         state     <= ST_INIT;
         clr_cnt   <= '0;
         uop2_hold <= '0;
         out_q     <= '0;
         out_q.clr <= 1'b1;
         err_o     <= 1'b0;
      end else begin
         // Any cycle without an issued micro-op leaves the datapath idle.
         out_q <= '0;
         err_o <= 1'b0;
         case (state)
            ST_INIT: begin
               if (clr_cnt == CW'(INIT_CLR_CYCLES - 1)) begin
                  state <= ST_RUN;
               end else begin
                  clr_cnt   <= clr_cnt + CW'(1);
                  out_q.clr <= 1'b1;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  out_q <= dec_uop1;
                  err_o <= dec_illegal;
                  if (dec_macro) begin
                     state     <= ST_MOV2;
                     uop2_hold <= dec_uop2;
                  end
               end
            end
            ST_MOV2: begin
               out_q <= uop2_hold;
               state <= ST_RUN;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   assign dp_clr_o = out_q.clr;
   assign dp_ce_o  = out_q.ce;
   assign dp_w_o   = out_q.w;
   assign dp_sel_o = out_q.sel;
   assign dp_s_o   = out_q.s;

endmodule
